param_shift_register: RTL and testbench
=======================================

Name: param_shift_register

Overview:
- Parametrised successor to the 16-bit left-shift/load register in the shift-and-add multiplier datapath.
- Supports configurable width, left/right logical shifts, arithmetic shift right, rotates and parallel load.
- Multi-bit shifts are executed one bit per cycle under a start/busy/done handshake.
- Used as the multiplier/product register and by the controller for N-step shift sequences.

Parameters:
- WIDTH, 16, register width in bits (>=2).
- CNT_W, clog2(WIDTH+1) (derived), width of the shift-amount field and internal counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable. When low, all state freezes, including the counter, FSM and q. Replaces the old gated-clock scheme.
- start  in  1  command strobe. Sampled only in IDLE or DONE with en=1.
- op  in  3  operation, latched on accepted start.
- amount  in  CNT_W  shift count, latched on accepted start.
- load_val  in  WIDTH  parallel load data.
- sin_lsb  in  1  serial input, enters bit 0 on SHL.
- sin_msb  in  1  serial input, enters bit WIDTH-1 on SHR.
- q  out  WIDTH  register contents.
- sout_msb  out  1  q[WIDTH-1].
- sout_lsb  out  1  q[0].
- busy  out  1  high in RUN.
- done  out  1  high for exactly one enabled cycle, in DONE.

Behaviour:
- Op encoding:
  - 0 HOLD
  - 1 LOAD
  - 2 SHL: q<={q[W-2:0],sin_lsb}
  - 3 SHR: q<={sin_msb,q[W-1:1]}
  - 4 ASR: MSB replicated
  - 5 ROL
  - 6 ROR
  - 7 reserved, treated as HOLD
- Reset (rst=1 at an edge, regardless of en):
  - q=0, busy=0, done=0, counter=0, state=IDLE.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE. All transitions require en=1.
- IDLE/DONE with start=1:
  - Latch op.
  - Latch cnt=min(amount,WIDTH); amounts above WIDTH clamp to WIDTH.
  - LOAD: q<=load_val at this edge, then go to DONE.
  - HOLD/reserved, or cnt==0 with any shift op: q unchanged, go to DONE.
  - Otherwise go to RUN; q is not changed at this edge.
- DONE with start=0: return to IDLE. done is therefore high for one enabled cycle.
- RUN, each enabled edge:
  - Perform one step of the latched op and decrement cnt.
  - If cnt was 1, go to DONE; otherwise stay in RUN.
- Latency:
  - An N-bit shift (1<=N<=WIDTH) gives busy high for N enabled cycles.
  - done rises after the Nth shift edge.
  - LOAD gives a done pulse in the cycle after the start edge.
- Serial inputs are sampled live at each shift edge, not latched at start.
- start during RUN is ignored; op/amount changes during RUN have no effect.
- en=0 during RUN stalls with busy held high. en=0 during DONE holds done high until the next enabled edge.
- A rotate by WIDTH returns the original value. ASR by WIDTH yields all copies of the original MSB.
- sout_msb/sout_lsb are combinational from q, so a controller reads the bit shifted out after each step.

Decomposition:
- Shared package shift_pkg:
  - op encoding constants (OP_HOLD..OP_ROR).
  - FSM state type (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module: shift_step, a purely combinational WIDTH-wide one-step next-value function of (q, op, sin_lsb, sin_msb).
- The top level holds the FSM, counter, load mux and registers.

Test Plan (WIDTH=16):
1. Reset and load:
   - Assert rst with en=1 → q=0x0000, busy=0, done=0.
   - LOAD 0xA5C3 → q=0xA5C3 after the start edge; done=1 the next cycle; busy never asserts.
2. SHL by 4:
   - From q=0x00F0 with sin_lsb=1 → busy for 4 cycles; q steps 0x01E1, 0x03C3, 0x0787, 0x0F0F.
   - sout_msb is 0 throughout; done is a single-cycle pulse.
3. ASR and SHR:
   - ASR by 3 on 0x8010 → 0xF002.
   - SHR by 3 on 0x8010 with sin_msb=0 → 0x1002.
4. Amount boundaries:
   - ROR amount=16 (full width) on 0x1234 → 0x1234 after 16 busy cycles.
   - amount=0 → done the next cycle, q unchanged.
   - SHL with amount=20 must not be applied when CNT_W=5 can encode it; clamp check uses WIDTH=8, amount=12 → 8 shifts.
5. Enable stall:
   - SHR by 4 with en low for 2 cycles after the second shift → q frozen and busy held during the stall.
   - Total 6 cycles; final value equals the unstalled run.
6. Abort and ignore:
   - rst during RUN → next cycle IDLE, q=0, no done.
   - start with op=LOAD during RUN → ignored; the shift completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the parametrised shift register:
// the operation encoding, the FSM state type and an op classifier.
package shift_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ASR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the ops that step the register once per cycle in RUN.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit step of the shift register: combinational next value of q
// for a single SHL/SHR/ASR/ROL/ROR step. Non-shift ops pass q through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_op,
    input  logic             i_sin_lsb,
    input  logic             i_sin_msb,
    output logic [WIDTH-1:0] o_q
);

    // Select the one-step result for the requested operation.
    always_comb begin
        o_q = i_q;
        case (i_op)
            OP_SHL:  o_q = {i_q[WIDTH-2:0], i_sin_lsb};
            OP_SHR:  o_q = {i_sin_msb, i_q[WIDTH-1:1]};
            OP_ASR:  o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            OP_ROL:  o_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            OP_ROR:  o_q = {i_q[0], i_q[WIDTH-1:1]};
            default: o_q = i_q;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Parametrised shift/load register. Multi-bit shifts run one bit per
// enabled cycle under a start/busy/done handshake; LOAD is immediate.
module param_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    // Derived from WIDTH; wide enough to hold the value WIDTH itself.
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    state_t           r_state;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_step_q;
    logic [CNT_W-1:0] w_amt_clamp;

    // Shifting further than the register width is never useful; a full
    // width rotate already returns the original value.
    assign w_amt_clamp = (amount > MAX_CNT) ? MAX_CNT : amount;

    // The step unit uses the latched op, so op changes during RUN are inert.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q       (r_q),
        .i_op      (r_op),
        .i_sin_lsb (sin_lsb),
        .i_sin_msb (sin_msb),
        .o_q       (w_step_q)
    );

    // Control FSM, counter and data register; everything holds when en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= OP_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_op  <= op;
                        r_cnt <= w_amt_clamp;
                        if (op == OP_LOAD) begin
                            r_q     <= load_val;
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (is_shift_op(op) && (w_amt_clamp != '0)) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: WIDTH=16 main instance plus a WIDTH=8
// instance for the amount clamp. Expected per-step values come from a
// bench-side model queued at start and popped as each shift lands.
module tb_param_shift_register;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, start, sin_lsb, sin_msb;
    logic [2:0]  op;
    logic [4:0]  amount;
    logic [15:0] load_val, q;
    logic        sout_msb, sout_lsb, busy, done;

    logic        start8;
    logic [3:0]  amount8;
    logic [7:0]  load_val8, q8;
    logic        sout_msb8, sout_lsb8, busy8, done8;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    param_shift_register #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .op(op), .amount(amount),
        .load_val(load_val), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q),
        .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
    );

    param_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .start(start8), .op(op), .amount(amount8),
        .load_val(load_val8), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q8),
        .sout_msb(sout_msb8), .sout_lsb(sout_lsb8), .busy(busy8), .done(done8)
    );

    function automatic logic [15:0] model_step(input logic [15:0] v, input logic [2:0] o,
                                               input logic sl, input logic sm);
        case (o)
            3'd2:    return (v << 1) | {15'b0, sl};
            3'd3:    return (v >> 1) | ({15'b0, sm} << 15);
            3'd4:    return $unsigned($signed(v) >>> 1);
            3'd5:    return (v << 1) | (v >> 15);
            3'd6:    return (v >> 1) | (v << 15);
            default: return v;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        en = 1'b1; op = OP_LOAD; load_val = v; start = 1'b1;
        tick();
        start = 1'b0; op = OP_HOLD;
        tick();
    endtask

    // Loads init, issues one command, then walks it to completion comparing
    // every step against the queued model values. A poke of start+LOAD on
    // the first RUN edge must be ignored.
    task automatic run_shift(input string nm, input logic [15:0] init, input logic [2:0] o,
                             input int amt, input logic sl, input logic sm,
                             input int stall_at, input int stall_n,
                             output logic [15:0] fin, output int cyc);
        int n, steps, stalls, guard;
        logic [15:0] cur, e;
        do_load(init);
        n = (o >= 3'd2 && o <= 3'd6) ? ((amt > 16) ? 16 : amt) : 0;
        exp_q.delete();
        cur = init;
        for (int i = 0; i < n; i++) begin
            cur = model_step(cur, o, sl, sm);
            exp_q.push_back(cur);
        end
        op = o; amount = amt[4:0]; sin_lsb = sl; sin_msb = sm; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (q !== init) begin
            failures++; $display("FAIL %s_start_q: q=%h expected %h", nm, q, init);
        end
        checks++;
        if (n == 0) begin
            if (done !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL %s_zero_done: done=%b busy=%b expected 1 0", nm, done, busy);
            end
        end else begin
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL %s_enter_run: busy=%b done=%b expected 1 0", nm, busy, done);
            end
            start = 1'b1; op = OP_LOAD; load_val = 16'hDEAD; amount = 5'd1;
        end
        steps = 0; stalls = 0; guard = 0; cyc = 0;
        while (exp_q.size() > 0) begin
            guard++;
            if (guard > 100) begin
                checks++; failures++;
                $display("FAIL %s_timeout: %0d steps left expected 0", nm, exp_q.size());
                exp_q.delete();
                break;
            end
            if (steps == stall_at && stalls < stall_n) begin
                e = q; en = 1'b0;
                tick();
                stalls++; cyc++; start = 1'b0;
                checks++;
                if (q !== e || busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_stall%0d: q=%h busy=%b done=%b expected q=%h busy=1 done=0",
                             nm, stalls, q, busy, done, e);
                end
                continue;
            end
            en = 1'b1;
            tick();
            steps++; cyc++; start = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (q !== e || sout_msb !== e[15] || sout_lsb !== e[0]) begin
                failures++;
                $display("FAIL %s_step%0d: q=%h msb=%b lsb=%b expected q=%h", nm, steps, q, sout_msb, sout_lsb, e);
            end
            checks++;
            if (exp_q.size() > 0) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    failures++; $display("FAIL %s_busy%0d: busy=%b done=%b expected 1 0", nm, steps, busy, done);
                end
            end else if (done !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL %s_done: done=%b busy=%b expected 1 0", nm, done, busy);
            end
        end
        fin = q;
        en = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_pulse_end: done=%b busy=%b expected 0 0", nm, done, busy);
        end
        op = OP_HOLD;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        tick(); tick();
        checks++;
        if (q !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset: q=%h busy=%b done=%b expected 0000 0 0", q, busy, done);
        end
        checks++;
        if (q8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++; $display("FAIL reset8: q=%h busy=%b done=%b expected 00 0 0", q8, busy8, done8);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        op = OP_LOAD; load_val = 16'hA5C3; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0; op = OP_HOLD;
        checks++;
        if (q !== 16'hA5C3 || done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL load: q=%h done=%b busy=%b expected a5c3 1 0", q, done, busy);
        end
        en = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("FAIL load_done_hold: done=%b expected 1", done);
        end
        en = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 16'hA5C3) begin
            failures++; $display("FAIL load_after: done=%b busy=%b q=%h expected 0 0 a5c3", done, busy, q);
        end
    endtask

    task automatic test_shl();
        logic [15:0] f; int c;
        run_shift("shl4", 16'h00F0, OP_SHL, 4, 1'b1, 1'b0, -1, 0, f, c);
        checks++;
        if (f !== 16'h0F0F || c !== 4) begin
            failures++; $display("FAIL shl4_final: q=%h cycles=%0d expected 0f0f 4", f, c);
        end
    endtask

    task automatic test_asr_shr();
        logic [15:0] f; int c;
        run_shift("asr3", 16'h8010, OP_ASR, 3, 1'b0, 1'b0, -1, 0, f, c);
        checks++;
        if (f !== 16'hF002 || c !== 3) begin
            failures++; $display("FAIL asr3_final: q=%h cycles=%0d expected f002 3", f, c);
        end
        run_shift("shr3", 16'h8010, OP_SHR, 3, 1'b0, 1'b0, -1, 0, f, c);
        checks++;
        if (f !== 16'h1002 || c !== 3) begin
            failures++; $display("FAIL shr3_final: q=%h cycles=%0d expected 1002 3", f, c);
        end
    endtask

    task automatic test_amount_bounds();
        logic [15:0] f; int c;
        run_shift("ror16", 16'h1234, OP_ROR, 16, 1'b0, 1'b0, -1, 0, f, c);
        checks++;
        if (f !== 16'h1234 || c !== 16) begin
            failures++; $display("FAIL ror16_final: q=%h cycles=%0d expected 1234 16", f, c);
        end
        run_shift("shl0", 16'hBEEF, OP_SHL, 0, 1'b1, 1'b1, -1, 0, f, c);
        checks++;
        if (f !== 16'hBEEF || c !== 0) begin
            failures++; $display("FAIL shl0_final: q=%h cycles=%0d expected beef 0", f, c);
        end
        run_shift("rol20", 16'h1234, OP_ROL, 20, 1'b0, 1'b0, -1, 0, f, c);
        checks++;
        if (f !== 16'h1234 || c !== 16) begin
            failures++; $display("FAIL rol20_final: q=%h cycles=%0d expected 1234 16", f, c);
        end
        run_shift("asr16", 16'h8001, OP_ASR, 16, 1'b0, 1'b0, -1, 0, f, c);
        checks++;
        if (f !== 16'hFFFF || c !== 16) begin
            failures++; $display("FAIL asr16_final: q=%h cycles=%0d expected ffff 16", f, c);
        end
        run_shift("rsvd", 16'h5A5A, 3'd7, 5, 1'b1, 1'b1, -1, 0, f, c);
        checks++;
        if (f !== 16'h5A5A || c !== 0) begin
            failures++; $display("FAIL rsvd_final: q=%h cycles=%0d expected 5a5a 0", f, c);
        end
    endtask

    task automatic test_clamp();
        int c;
        en = 1'b1; op = OP_LOAD; load_val8 = 8'h81; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        op = OP_ROL; amount8 = 4'd12; start8 = 1'b1;
        tick();
        start8 = 1'b0; op = OP_HOLD;
        c = 0;
        while (done8 !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        checks++;
        if (c !== 8 || q8 !== 8'h81) begin
            failures++; $display("FAIL clamp8: cycles=%0d q=%h expected 8 81", c, q8);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [15:0] f; int c;
        run_shift("shr4_stall", 16'hF0F0, OP_SHR, 4, 1'b0, 1'b1, 2, 2, f, c);
        checks++;
        if (f !== 16'hFF0F || c !== 6) begin
            failures++; $display("FAIL shr4_stall_final: q=%h cycles=%0d expected ff0f 6", f, c);
        end
    endtask

    task automatic test_abort();
        do_load(16'h00FF);
        op = OP_SHL; amount = 5'd8; sin_lsb = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || q !== 16'h07F8) begin
            failures++; $display("FAIL abort_pre: busy=%b q=%h expected 1 07f8", busy, q);
        end
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1;
        checks++;
        if (q !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_rst: q=%h busy=%b done=%b expected 0000 0 0", q, busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL abort_no_done%0d: done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
        op = OP_HOLD;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; op = OP_HOLD; amount = '0; load_val = '0;
        sin_lsb = 1'b0; sin_msb = 1'b0; start8 = 1'b0; amount8 = '0; load_val8 = '0;
        test_reset();
        test_load();
        test_shl();
        test_asr_shr();
        test_amount_bounds();
        test_clamp();
        test_stall();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
